// File: rtl/tile_store_pkg.sv
// Shared types and helpers for the tile store engine: FSM state encoding,
// default geometry and the per-lane strobe rule.
package tile_store_pkg;

   localparam int DEF_ADDR_WIDTH = 24;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_TILE_WIDTH = 256;
   localparam int DEF_TILE_ELEMS = DEF_TILE_WIDTH / DEF_DATA_WIDTH;
   localparam int DEF_LANES      = 4;
   localparam int DEF_LEN_WIDTH  = 16;
   localparam int BEATS_PER_TILE = DEF_TILE_ELEMS / DEF_LANES;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WRITE  = 3'd2,
      S_NEXT   = 3'd3,
      S_FINISH = 3'd4
   } state_e;

   // A lane is written only while elements remain for it in this beat.
   function automatic logic lane_strobe(input int unsigned lane, input logic [31:0] remaining);
      return (lane < remaining);
   endfunction

endpackage

// File: rtl/tile_store_engine_if.sv
// DRAM write port of the tile store engine: valid/ready beat channel with
// per-lane strobes plus the completion dump request.
interface tile_store_engine_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4
);
   logic                        mem_wvalid;
   logic                        mem_wready;
   logic [ADDR_WIDTH-1:0]       mem_waddr;
   logic [LANES*DATA_WIDTH-1:0] mem_wdata;
   logic [LANES-1:0]            mem_wstrb;
   logic                        mem_dump;

   modport master (
      output mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, mem_dump,
      input  mem_wready
   );

   modport slave (
      input  mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, mem_dump,
      output mem_wready
   );
endinterface

// File: rtl/tile_store_beat_mux.sv
// Selects the current beat's LANES elements out of the captured tile and
// builds the lane strobes from the element count still to be written.
module tile_store_beat_mux
   import tile_store_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_ELEMS = 32,
   parameter int LANES      = 4,
   parameter int LEN_WIDTH  = 16,
   parameter int BEAT_W     = 3
) (
   input  logic [TILE_ELEMS*DATA_WIDTH-1:0] tile_data,
   input  logic [BEAT_W-1:0]                beat,
   input  logic [LEN_WIDTH-1:0]             remaining,
   output logic [LANES*DATA_WIDTH-1:0]      beat_data,
   output logic [LANES-1:0]                 beat_strb
);
   localparam int SLICE_W = LANES * DATA_WIDTH;

   always_comb begin
      beat_data = tile_data[int'(beat) * SLICE_W +: SLICE_W];
      beat_strb = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         beat_strb[i] = lane_strobe(i, 32'(remaining));
      end
   end

endmodule

// File: rtl/tile_store_engine.sv
// Tile store engine: streams `length` buffer elements to DRAM in LANES-wide
// beats, fetching one tile at a time and stepping the DRAM base by a stride.
module tile_store_engine
   import tile_store_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TILE_WIDTH = DEF_TILE_WIDTH,
   parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
   parameter int LANES      = DEF_LANES,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            dram_addr,
   input  logic [ADDR_WIDTH-1:0]            dram_stride,
   input  logic [LEN_WIDTH-1:0]             length,
   input  logic [4:0]                       buf_id,
   output logic                             buf_read_en,
   output logic [4:0]                       buf_read_id,
   input  logic [TILE_ELEMS*DATA_WIDTH-1:0] buf_read_data,
   input  logic                             buf_read_done,
   tile_store_engine_if.master              mem,
   output logic                             busy,
   output logic                             done
);
   localparam int TILE_BEATS = TILE_ELEMS / LANES;
   localparam int BEAT_W     = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;

   if (TILE_ELEMS % LANES != 0) begin : g_bad_lanes
      $error("tile_store_engine: TILE_ELEMS must be a multiple of LANES");
   end

   state_e                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           base_q, base_d;
   logic [ADDR_WIDTH-1:0]           stride_q, stride_d;
   logic [LEN_WIDTH-1:0]            remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]            step_s;
   logic [BEAT_W-1:0]               beat_q, beat_d;
   logic [4:0]                      id_q, id_d;
   logic [TILE_ELEMS*DATA_WIDTH-1:0] tile_q, tile_d;
   logic [LANES*DATA_WIDTH-1:0]     beat_data_s;
   logic [LANES-1:0]                beat_strb_s;

   tile_store_beat_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .TILE_ELEMS (TILE_ELEMS),
      .LANES      (LANES),
      .LEN_WIDTH  (LEN_WIDTH),
      .BEAT_W     (BEAT_W)
   ) u_beat_mux (
      .tile_data (tile_q),
      .beat      (beat_q),
      .remaining (remaining_q),
      .beat_data (beat_data_s),
      .beat_strb (beat_strb_s)
   );

   // State, transfer context and captured tile registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
         beat_q      <= '0;
         id_q        <= 5'd0;
         tile_q      <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         stride_q    <= stride_d;
         remaining_q <= remaining_d;
         beat_q      <= beat_d;
         id_q        <= id_d;
         tile_q      <= tile_d;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      stride_d    = stride_q;
      remaining_d = remaining_q;
      beat_d      = beat_q;
      id_d        = id_q;
      tile_d      = tile_q;
      step_s      = (remaining_q < LEN_WIDTH'(LANES)) ? remaining_q : LEN_WIDTH'(LANES);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d      = dram_addr;
               // A zero stride means tiles are packed back to back.
               stride_d    = (dram_stride == '0) ? ADDR_WIDTH'(TILE_ELEMS) : dram_stride;
               remaining_d = length;
               id_d        = buf_id;
               state_d     = (length == '0) ? S_FINISH : S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (buf_read_done) begin
               tile_d  = buf_read_data;
               beat_d  = '0;
               state_d = S_WRITE;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WRITE: begin
            if (mem.mem_wready) begin
               remaining_d = remaining_q - step_s;
               beat_d      = beat_q + BEAT_W'(1);
               if (remaining_d == '0) begin
                  state_d = S_FINISH;
               end else if (beat_q == BEAT_W'(TILE_BEATS - 1)) begin
                  state_d = S_NEXT;
               end else begin
                  state_d = S_WRITE;
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         S_NEXT: begin
            base_d  = base_q + stride_q;
            state_d = S_REQ;
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore output decode; beat fields are zero outside S_WRITE.
   always_comb begin
      buf_read_en    = 1'b0;
      buf_read_id    = id_q;
      mem.mem_wvalid = 1'b0;
      mem.mem_waddr  = '0;
      mem.mem_wdata  = '0;
      mem.mem_wstrb  = '0;
      mem.mem_dump   = 1'b0;
      done           = 1'b0;
      busy           = (state_q != S_IDLE);
      case (state_q)
         S_REQ: begin
            buf_read_en = 1'b1;
         end
         S_WRITE: begin
            mem.mem_wvalid = 1'b1;
            mem.mem_waddr  = base_q + ADDR_WIDTH'(int'(beat_q) * LANES);
            mem.mem_wdata  = beat_data_s;
            mem.mem_wstrb  = beat_strb_s;
         end
         S_FINISH: begin
            done         = 1'b1;
            mem.mem_dump = 1'b1;
         end
         default: begin
            busy = (state_q != S_IDLE);
         end
      endcase
   end

endmodule
